// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter: one log2(WIDTH) stage per amount bit, valid/ready flow control.
// Optional out_zero/out_carry flags are built when BARREL_FLAGS_EN is defined.
module pipelined_barrel_shifter #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW:0]      occupancy
`ifdef BARREL_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_carry
`endif
);

    localparam int unsigned OW = AW + 1;

    logic advance;
    logic in_fire;
    logic out_fire;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign in_fire  = in_valid && advance;
    assign out_fire = out_valid && out_ready;

    for (genvar k = 0; k < AW; k++) begin : g_stage
        localparam int unsigned SH = 32'd1 << k;
        localparam int unsigned RW = AW - k;

        logic [WIDTH-1:0] d_in;
        logic [WIDTH-1:0] d_nxt;
        logic [WIDTH-1:0] data_q;
        logic [RW-1:0]    a_in;
        logic [2:0]       m_in;
        logic             v_in;
        logic             valid_q;
`ifdef BARREL_FLAGS_EN
        localparam logic [WIDTH-1:0] RMASK = WIDTH'(1) << (SH - 1);
        localparam logic [WIDTH-1:0] LMASK = WIDTH'(1) << (WIDTH - SH);
        logic c_in;
        logic c_nxt;
        logic carry_q;
`endif

        if (k == 0) begin : g_head
            assign d_in = in_data;
            assign a_in = in_amt;
            assign m_in = in_mode;
            assign v_in = in_valid;
`ifdef BARREL_FLAGS_EN
            assign c_in = 1'b0;
`endif
        end else begin : g_link
            assign d_in = g_stage[k-1].data_q;
            assign a_in = g_stage[k-1].g_fwd.amt_q;
            assign m_in = g_stage[k-1].g_fwd.mode_q;
            assign v_in = g_stage[k-1].valid_q;
`ifdef BARREL_FLAGS_EN
            assign c_in = g_stage[k-1].carry_q;
`endif
        end

        // Bit 0 of the remaining amount selects this stage's 2^k shift.
        always_comb begin
            d_nxt = d_in;
            if (a_in[0]) begin
                case (m_in[2:1])
                    2'b00:   d_nxt = m_in[0] ? (d_in >> SH) : (d_in << SH);
                    2'b01:   d_nxt = m_in[0] ? $unsigned($signed(d_in) >>> SH) : (d_in << SH);
                    2'b10:   d_nxt = m_in[0] ? ((d_in >> SH) | (d_in << (WIDTH - SH)))
                                             : ((d_in << SH) | (d_in >> (WIDTH - SH)));
                    default: d_nxt = d_in;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (advance) begin
                data_q  <= d_nxt;
                valid_q <= v_in;
            end
        end

`ifdef BARREL_FLAGS_EN
        // Later stages shift further, so the highest active stage owns the carry.
        always_comb begin
            c_nxt = c_in;
            if (a_in[0] && (m_in[2:1] != 2'b11)) begin
                c_nxt = m_in[0] ? |(d_in & RMASK) : |(d_in & LMASK);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                carry_q <= 1'b0;
            end else if (advance) begin
                carry_q <= c_nxt;
            end
        end
`endif

        if (k < AW - 1) begin : g_fwd
            logic [RW-2:0] amt_q;
            logic [2:0]    mode_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    amt_q  <= '0;
                    mode_q <= '0;
                end else if (advance) begin
                    amt_q  <= a_in[RW-1:1];
                    mode_q <= m_in;
                end
            end
        end
    end

    assign out_valid = g_stage[AW-1].valid_q;
    assign out_data  = g_stage[AW-1].data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   occupancy <= occupancy + OW'(1);
                2'b01:   occupancy <= occupancy - OW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

`ifdef BARREL_FLAGS_EN
    logic zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else if (advance) begin
            zero_q <= (g_stage[AW-1].d_nxt == '0);
        end
    end

    assign out_zero  = zero_q;
    assign out_carry = g_stage[AW-1].carry_q;
`endif

endmodule
